// File: rtl/urate.sv
// Up-rate interpolator: zero-stuffs low-rate samples by R = F_H/F_L and filters
// them with a parallel direct-form FIR whose coefficients come from an external bus.
module urate #(
  parameter int DWIDTH     = 16,
  parameter int F_H        = 60,
  parameter int F_L        = 3,
  parameter int FIR_CWIDTH = 16,
  parameter int FIR_TAPS   = 64,
  parameter int FIR_SLICE  = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FIR_TAPS*FIR_CWIDTH-1:0]     fir_coefs,
  input  logic signed [DWIDTH-1:0]           in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [DWIDTH-1:0]           out,
  output logic                               underrun
);

  localparam int R      = F_H / F_L;
  localparam int CNT_W  = (R > 1) ? $clog2(R) : 1;
  localparam int PROD_W = DWIDTH + FIR_CWIDTH;
  localparam int ACC_W  = PROD_W + $clog2(FIR_TAPS);

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(R - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  logic [CNT_W-1:0]             slot_cnt;
  logic                         slot_tc;
  logic signed [DWIDTH-1:0]     x;
  logic signed [DWIDTH-1:0]     dly [FIR_TAPS];
  logic signed [FIR_CWIDTH-1:0] coef [FIR_TAPS];
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      y;
  logic signed [DWIDTH-1:0]     out_next;

  // Slot timer runs down from R-1; terminal count 0 is the one input slot per period.
  assign slot_tc  = (slot_cnt == '0);
  assign in_ready = slot_tc & rst;
  assign x        = (slot_tc && in_valid) ? in : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
    end else if (slot_tc) begin
      slot_cnt <= CNT_LAST;
    end else begin
      slot_cnt <= slot_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < FIR_TAPS; j++) dly[j] <= '0;
    end else begin
      dly[0] <= x;
      for (int j = 1; j < FIR_TAPS; j++) dly[j] <= dly[j-1];
    end
  end

  always_comb begin
    for (int j = 0; j < FIR_TAPS; j++) coef[j] = fir_coefs[j*FIR_CWIDTH +: FIR_CWIDTH];
  end

  // Full-precision sum; accumulator is sized so it can never overflow.
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int j = 0; j < FIR_TAPS; j++) begin
      prod = PROD_W'(dly[j]) * PROD_W'(coef[j]);
      acc  = acc + ACC_W'(prod);
    end
    y        = acc >>> FIR_SLICE;
    out_next = y[DWIDTH-1:0];
    if (y > SAT_MAX) begin
      out_next = {1'b0, {(DWIDTH-1){1'b1}}};
    end else if (y < SAT_MIN) begin
      out_next = {1'b1, {(DWIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out      <= '0;
      underrun <= 1'b0;
    end else begin
      out      <= out_next;
      underrun <= slot_tc & ~in_valid;
    end
  end

endmodule

// File: tb/tb_urate.sv
// Bench for urate: two instances (slice 15 and 14) share stimulus; an arithmetic
// model of the zero-stuffed FIR is compared every cycle, plus literal spot checks.
module tb_urate;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 64;
  localparam int R  = 20;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NT*CW-1:0]     coefs = '0;
  logic signed [DW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic                 rdy_a, rdy_b, unr_a, unr_b;
  logic signed [DW-1:0] out_a, out_b;

  urate #(.FIR_SLICE(15)) u_a (
    .clk(clk), .rst(rst_n), .fir_coefs(coefs), .in(din), .in_valid(din_valid),
    .in_ready(rdy_a), .out(out_a), .underrun(unr_a));

  urate #(.FIR_SLICE(14)) u_b (
    .clk(clk), .rst(rst_n), .fir_coefs(coefs), .in(din), .in_valid(din_valid),
    .in_ready(rdy_b), .out(out_b), .underrun(unr_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: history of the stuffed sequence, cycle count since release.
  longint hist [NT];
  int     cyc = 0;
  longint exp_a = 0, exp_b = 0;
  bit     exp_unr = 1'b0;
  bit     chk_en = 1'b0;

  function automatic longint fir(input int slice);
    longint acc = 0;
    longint yv;
    for (int j = 0; j < NT; j++) acc += hist[j] * longint'($signed(coefs[j*CW +: CW]));
    yv = acc >>> slice;
    if (yv > 32767) yv = 32767;
    if (yv < -32768) yv = -32768;
    return yv;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc     <= 0;
      exp_a   <= 0;
      exp_b   <= 0;
      exp_unr <= 1'b0;
      for (int i = 0; i < NT; i++) hist[i] <= 0;
    end else begin
      exp_a   <= fir(15);
      exp_b   <= fir(14);
      exp_unr <= (cyc % R == 0) && !din_valid;
      hist[0] <= ((cyc % R == 0) && din_valid) ? longint'(din) : 64'sd0;
      for (int i = 1; i < NT; i++) hist[i] <= hist[i-1];
      cyc     <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_a", out_a, exp_a);
      check("out_b", out_b, exp_b);
      check("underrun_a", unr_a, exp_unr);
      check("underrun_b", unr_b, exp_unr);
      check("in_ready_a", rdy_a, rst_n && (cyc % R == 0));
      check("in_ready_b", rdy_b, rst_n && (cyc % R == 0));
    end
  end

  task automatic wait_slot();
    int n = 0;
    while (!rdy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_a) check("slot_timeout", rdy_a, 1);
  endtask

  task automatic send(input logic signed [DW-1:0] v, input bit keep_valid);
    wait_slot();
    din       = v;
    din_valid = 1'b1;
    @(negedge clk);
    if (!keep_valid) din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_underrun", unr_a, 0);
    check("rst_in_ready", rdy_a, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("rel_in_ready", rdy_a, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    int nz;
    #1 chk_en = 1'b1;
    do_reset();

    // Impulse response on ramp coefficients
    for (int j = 0; j < NT; j++) coefs[j*CW +: CW] = 16'((j + 1) * 500);
    send(16'sd1000, 1'b1);
    din = '0;
    for (int j = 0; j < 70; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("imp_j0_a", out_a, 15);
        check("imp_j0_b", out_b, 30);
      end
      if (j == 63) check("imp_j63_a", out_a, 976);
      if (j == 64) check("imp_j64_a", out_a, 0);
    end
    wait_slot();
    cnt = 0;
    @(negedge clk);
    cnt++;
    while (!rdy_a && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_period", cnt, R);

    // Underrun: one empty slot between two impulses
    do_reset();
    send(16'sd1000, 1'b0);
    wait_slot();
    @(negedge clk);
    check("underrun_hi", unr_a, 1);
    @(negedge clk);
    check("underrun_lo", unr_a, 0);
    send(16'sd1000, 1'b0);
    repeat (70) @(negedge clk);

    // Pass-through with in_valid held high between slots
    do_reset();
    coefs = '0;
    coefs[CW-1:0] = 16'sd16384;
    din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic signed [DW-1:0] v;
      v = (k == 0) ? 16'sd100 : (k == 1) ? -16'sd200 : 16'sd300;
      wait_slot();
      din = v;
      @(negedge clk);
      @(negedge clk);
      check("pt_out_b", out_b, v);
      nz = 0;
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        if (out_b != 0) nz++;
      end
      check("pt_gap_nonzero", nz, 0);
    end

    // Hold interpolation, then async reset at phase 7
    for (int j = 0; j < NT; j++) coefs[j*CW +: CW] = (j < R) ? 16'sd16384 : 16'sd0;
    din = -16'sd500;
    din_valid = 1'b1;
    repeat (60) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 2 * R; i++) begin
      @(negedge clk);
      if (out_b != -500) nz++;
    end
    check("hold_gaps_b", nz, 0);
    check("hold_out_a", out_a, -250);
    wait_slot();
    repeat (7) @(negedge clk);
    check("pre_rst_out_b", out_b, -500);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_b", out_b, 0);
    check("mid_rst_out_a", out_a, 0);
    check("mid_rst_in_ready", rdy_a, 0);
    check("mid_rst_underrun", unr_a, 0);
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("post_rel_in_ready", rdy_a, 1);
    check("post_rel_out_b", out_b, 0);
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_b != 0 || out_a != 0) nz++;
    end
    check("post_rel_quiet", nz, 0);

    // Saturation at both rails
    for (int j = 0; j < NT; j++) coefs[j*CW +: CW] = 16'sd32767;
    din = 16'sd32767;
    din_valid = 1'b1;
    repeat (100) @(negedge clk);
    check("sat_pos_a", out_a, 32767);
    check("sat_pos_b", out_b, 32767);
    din = -16'sd32768;
    repeat (100) @(negedge clk);
    check("sat_neg_a", out_a, -32768);
    check("sat_neg_b", out_b, -32768);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
